mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default params_pkg::OPCODE_WIDTH, width of the instruction opcode field.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 instr_i  input  32  current instruction from the datapath instruction register.
REQ-006 mem_ready_i  input  1  memory completes the current request this cycle.
REQ-007 is_zero_i, is_less_i  input  1 each  ALU compare flags (rs1-rs2 zero / signed less).
REQ-008 mem_req_o, mem_we_o  output  1 each  memory request / write enable.
REQ-009 mem_addr_sel_o  output  1  0=PC, 1=ALU result register.
REQ-010 ir_we_o, pc_we_o, rf_we_o  output  1 each  instruction register / PC / register file write enables.
REQ-011 pc_src_o  output  2  00=PC+4, 01=ALU result, 10=branch target (old PC+imm).
REQ-012 alu_a_sel_o  output  2  00=rs1, 01=old PC, 10=zero.
REQ-013 alu_b_sel_o  output  2  00=rs2, 01=immediate.
REQ-014 wb_sel_o  output  2  00=ALU result register, 01=memory data, 10=old PC+4.
REQ-015 state_o  output  3  current state encoding; illegal_o  output  1  sticky illegal-instruction flag.
REQ-016 instret_o  output  32  retired-instruction counter.

Function
REQ-017 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP; state_o encodings 0-5 in that order.
REQ-018 SHALL decode opcode = instr_i[OPCODE_WIDTH-1:0] against params_pkg opcode values R, IMMEDIATE, LOAD, STORE, BRANCH, JAL, LUI, AUIPC; funct3 = instr_i[14:12].
REQ-019 FETCH: mem_req_o=1, mem_addr_sel_o=0, mem_we_o=0; remain while mem_ready_i=0; on mem_ready_i=1 assert ir_we_o and pc_we_o with pc_src_o=00 in that same cycle, next state DECODE.
REQ-020 mem_req_o and all select outputs SHALL stay constant while waiting for mem_ready_i; mem_ready_i SHALL be ignored whenever mem_req_o=0.
REQ-021 DECODE: one cycle, all enables 0; unknown opcode -> TRAP, else EXECUTE.
REQ-022 EXECUTE selects: R a=00 b=00; IMMEDIATE/LOAD/STORE a=00 b=01; LUI a=10 b=01; AUIPC/JAL a=01 b=01; BRANCH a=00 b=00.
REQ-023 EXECUTE next state: LOAD/STORE -> MEMORY; R/IMMEDIATE/LUI/AUIPC/JAL -> WRITEBACK; BRANCH -> FETCH.
REQ-024 BRANCH taken rule in EXECUTE: funct3 000 is_zero_i; 001 !is_zero_i; 100 is_less_i; 101 !is_less_i; taken -> pc_we_o=1, pc_src_o=10; any other funct3 -> TRAP, no PC write.
REQ-025 JAL in EXECUTE: pc_we_o=1, pc_src_o=01 (PC <= old PC + imm).
REQ-026 MEMORY: mem_req_o=1, mem_addr_sel_o=1, mem_we_o=1 for STORE only; wait on mem_ready_i; on ready LOAD -> WRITEBACK, STORE -> FETCH.
REQ-027 WRITEBACK: one cycle, rf_we_o=1; wb_sel_o 01 for LOAD, 10 for JAL, 00 otherwise; next FETCH.
REQ-028 Retirement cycle = WRITEBACK, BRANCH EXECUTE (legal funct3), STORE MEMORY with mem_ready_i=1; instret_o SHALL increment by 1 on that edge, wrapping 0xFFFFFFFF -> 0.
REQ-029 Zero-wait latencies: R/IMMEDIATE/LUI/AUIPC/JAL/STORE 4 cycles, LOAD 5, BRANCH 3; each memory wait cycle adds one.
REQ-030 TRAP: illegal_o=1, all enables and mem_req_o 0, no exit except reset; instret_o frozen.
REQ-031 Outputs not listed as asserted in a state SHALL be 0 in that state (Moore outputs plus the mem_ready_i-qualified enables above).

Reset
REQ-032 rst_i=1 at an edge SHALL set state FETCH, illegal_o=0, instret_o=0, overriding any in-progress memory wait or TRAP.
REQ-033 While rst_i=1 all write enables and mem_req_o SHALL be 0; FETCH outputs appear the first cycle rst_i=0.

Verification
REQ-034 ADD x1,x2,x3 (0x003100B3), mem_ready_i always 1 -> states 0,1,2,4; rf_we_o=1 in cycle 4, wb_sel_o=00; instret_o=1.
REQ-035 LW with mem_ready_i low 2 cycles in MEMORY -> mem_req_o=1, mem_addr_sel_o=1 held 3 cycles; WRITEBACK wb_sel_o=01; total 7 cycles.
REQ-036 BEQ with is_zero_i=1 -> pc_we_o=1, pc_src_o=10 in EXECUTE; same with is_zero_i=0 -> pc_we_o=0; both retire, 3 cycles.
REQ-037 opcode 0x7F, or BRANCH funct3=010 -> TRAP, illegal_o=1 stays set 20 cycles, no enables; rst_i pulse -> FETCH, illegal_o=0.
REQ-038 instret_o preloaded to 0xFFFFFFFF via 2^32-1 retirements is impractical; bench forces counter to 0xFFFFFFFF then retires one ADD -> instret_o=0.
REQ-039 rst_i asserted during FETCH memory wait -> next cycle mem_req_o=0, then fresh FETCH; earlier pending mem_ready_i causes no ir_we_o.

Source files
------------

// File: rtl/params_pkg.sv
// Shared ISA constants: opcode field width and RV32I major opcodes.
package params_pkg;

    parameter int unsigned OPCODE_WIDTH = 7;

    localparam logic [6:0] OpcodeR         = 7'h33;
    localparam logic [6:0] OpcodeImmediate = 7'h13;
    localparam logic [6:0] OpcodeLoad      = 7'h03;
    localparam logic [6:0] OpcodeStore     = 7'h23;
    localparam logic [6:0] OpcodeBranch    = 7'h63;
    localparam logic [6:0] OpcodeJal       = 7'h6F;
    localparam logic [6:0] OpcodeLui       = 7'h37;
    localparam logic [6:0] OpcodeAuipc     = 7'h17;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback,
// plus a sticky trap state for illegal instructions. Drives datapath selects
// and enables, and counts retired instructions.
module mc_control #(
    parameter int unsigned OPCODE_WIDTH = params_pkg::OPCODE_WIDTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        mem_ready_i,
    input  logic        is_zero_i,
    input  logic        is_less_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        rf_we_o,
    output logic [1:0]  pc_src_o,
    output logic [1:0]  alu_a_sel_o,
    output logic [1:0]  alu_b_sel_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StTrap      = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             instret_q;
    logic                    retire;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [2:0]              funct3;
    logic op_r, op_imm, op_load, op_store, op_branch, op_jal, op_lui, op_auipc, op_legal;

    // Only opcode and funct3 steer control; the rest of the word is datapath-only.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[31:15], instr_i[11:0]};

    assign opcode = instr_i[OPCODE_WIDTH-1:0];
    assign funct3 = instr_i[14:12];

    // Opcode class decode; the IR holds the instruction from DECODE onwards.
    always_comb begin
        op_r      = 1'b0;
        op_imm    = 1'b0;
        op_load   = 1'b0;
        op_store  = 1'b0;
        op_branch = 1'b0;
        op_jal    = 1'b0;
        op_lui    = 1'b0;
        op_auipc  = 1'b0;
        case (opcode)
            OPCODE_WIDTH'(params_pkg::OpcodeR):         op_r      = 1'b1;
            OPCODE_WIDTH'(params_pkg::OpcodeImmediate): op_imm    = 1'b1;
            OPCODE_WIDTH'(params_pkg::OpcodeLoad):      op_load   = 1'b1;
            OPCODE_WIDTH'(params_pkg::OpcodeStore):     op_store  = 1'b1;
            OPCODE_WIDTH'(params_pkg::OpcodeBranch):    op_branch = 1'b1;
            OPCODE_WIDTH'(params_pkg::OpcodeJal):       op_jal    = 1'b1;
            OPCODE_WIDTH'(params_pkg::OpcodeLui):       op_lui    = 1'b1;
            OPCODE_WIDTH'(params_pkg::OpcodeAuipc):     op_auipc  = 1'b1;
            default: ;
        endcase
        op_legal = op_r | op_imm | op_load | op_store | op_branch | op_jal | op_lui | op_auipc;
    end

    // Next-state and output decode; enables that depend on mem_ready_i are
    // only raised in states that hold mem_req_o high.
    always_comb begin
        state_d        = state_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        rf_we_o        = 1'b0;
        pc_src_o       = 2'b00;
        alu_a_sel_o    = 2'b00;
        alu_b_sel_o    = 2'b00;
        wb_sel_o       = 2'b00;
        retire         = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = op_legal ? StExecute : StTrap;
            end
            StExecute: begin
                if (op_r) begin
                    state_d = StWriteback;
                end else if (op_imm || op_load || op_store) begin
                    alu_b_sel_o = 2'b01;
                    state_d     = (op_load || op_store) ? StMemory : StWriteback;
                end else if (op_lui) begin
                    alu_a_sel_o = 2'b10;
                    alu_b_sel_o = 2'b01;
                    state_d     = StWriteback;
                end else if (op_auipc || op_jal) begin
                    alu_a_sel_o = 2'b01;
                    alu_b_sel_o = 2'b01;
                    if (op_jal) begin
                        pc_we_o  = 1'b1;
                        pc_src_o = 2'b01;
                    end
                    state_d = StWriteback;
                end else if (op_branch) begin
                    // Branches retire here; unsupported funct3 traps without a PC write.
                    state_d = StFetch;
                    retire  = 1'b1;
                    case (funct3)
                        3'b000:  pc_we_o = is_zero_i;
                        3'b001:  pc_we_o = !is_zero_i;
                        3'b100:  pc_we_o = is_less_i;
                        3'b101:  pc_we_o = !is_less_i;
                        default: begin
                            state_d = StTrap;
                            retire  = 1'b0;
                        end
                    endcase
                    if (pc_we_o) begin
                        pc_src_o = 2'b10;
                    end
                end else begin
                    state_d = StTrap;
                end
            end
            StMemory: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = op_store;
                if (mem_ready_i) begin
                    if (op_store) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end
            end
            StWriteback: begin
                rf_we_o  = 1'b1;
                wb_sel_o = op_load ? 2'b01 : (op_jal ? 2'b10 : 2'b00);
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StTrap: ;
            default: state_d = StTrap;
        endcase

        // Reset suppresses every side effect in the cycle it is asserted.
        if (rst_i) begin
            mem_req_o = 1'b0;
            mem_we_o  = 1'b0;
            ir_we_o   = 1'b0;
            pc_we_o   = 1'b0;
            rf_we_o   = 1'b0;
            retire    = 1'b0;
        end
    end

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StFetch;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign state_o   = state_q;
    assign illegal_o = (state_q == StTrap);
    assign instret_o = instret_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle output vectors hand-derived from
// the control table, one task per scenario.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready, is_zero, is_less;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
    logic [1:0]  pc_src, alu_a_sel, alu_b_sel, wb_sel;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instret;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_instret = 32'd0;
    logic [17:0] f_rdy, f_wait, dec, idle;

    always #5 clk = ~clk;

    mc_control dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_i        (instr),
        .mem_ready_i    (mem_ready),
        .is_zero_i      (is_zero),
        .is_less_i      (is_less),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_sel_o (mem_addr_sel),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .rf_we_o        (rf_we),
        .pc_src_o       (pc_src),
        .alu_a_sel_o    (alu_a_sel),
        .alu_b_sel_o    (alu_b_sel),
        .wb_sel_o       (wb_sel),
        .state_o        (state),
        .illegal_o      (illegal),
        .instret_o      (instret)
    );

    // {state, req, we, addr_sel, ir_we, pc_we, rf_we, pc_src, a_sel, b_sel, wb_sel, illegal}
    function automatic logic [17:0] v(input int st, input int req, input int we, input int asel,
                                      input int irwe, input int pcwe, input int rfwe,
                                      input int pcsrc, input int a, input int b, input int wb,
                                      input int ill);
        return {st[2:0], req[0], we[0], asel[0], irwe[0], pcwe[0], rfwe[0], pcsrc[1:0],
                a[1:0], b[1:0], wb[1:0], ill[0]};
    endfunction

    function automatic logic [17:0] outs();
        return {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, pc_src,
                alu_a_sel, alu_b_sel, wb_sel, illegal};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== idle) begin
            n_bad++; $display("FAIL reset_outs: got %b want %b", outs(), idle);
        end
        n_cmp++;
        if (instret !== 32'd0) begin
            n_bad++; $display("FAIL reset_instret: got %h want 0", instret);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== f_wait) begin
            n_bad++; $display("FAIL reset_release: got %b want %b", outs(), f_wait);
        end
    endtask

    task automatic test_add();
        logic [17:0] exp [4];
        instr = 32'h003100B3;
        exp = '{f_rdy, dec, v(2,0,0,0,0,0,0,0,0,0,0,0), v(4,0,0,0,0,0,1,0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            n_cmp++;
            if (outs() !== exp[i]) begin
                n_bad++; $display("FAIL add cyc%0d: got %b want %b", i, outs(), exp[i]);
            end
            @(posedge clk); #1;
        end
        exp_instret++;
        n_cmp++;
        if (state !== 3'd0 || instret !== exp_instret) begin
            n_bad++; $display("FAIL add_retire: got st=%0d ir=%h want st=0 ir=%h",
                              state, instret, exp_instret);
        end
    endtask

    task automatic test_fetch_wait();
        logic [17:0] exp [6];
        logic        rdy [6];
        instr = 32'h003100B3;
        exp = '{f_wait, f_wait, f_rdy, dec, v(2,0,0,0,0,0,0,0,0,0,0,0),
                v(4,0,0,0,0,0,1,0,0,0,0,0)};
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i]; #1;
            n_cmp++;
            if (outs() !== exp[i]) begin
                n_bad++; $display("FAIL fetch_wait cyc%0d: got %b want %b", i, outs(), exp[i]);
            end
            @(posedge clk); #1;
        end
        exp_instret++;
        n_cmp++;
        if (state !== 3'd0 || instret !== exp_instret) begin
            n_bad++; $display("FAIL fetch_wait_retire: got st=%0d ir=%h want st=0 ir=%h",
                              state, instret, exp_instret);
        end
    endtask

    task automatic test_load();
        logic [17:0] exp [7];
        logic        rdy [7];
        logic [17:0] mem;
        instr = 32'h00012083;
        mem = v(3,1,0,1,0,0,0,0,0,0,0,0);
        exp = '{f_rdy, dec, v(2,0,0,0,0,0,0,0,0,1,0,0), mem, mem, mem,
                v(4,0,0,0,0,0,1,0,0,0,1,0)};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i]; #1;
            n_cmp++;
            if (outs() !== exp[i]) begin
                n_bad++; $display("FAIL load cyc%0d: got %b want %b", i, outs(), exp[i]);
            end
            @(posedge clk); #1;
        end
        exp_instret++;
        n_cmp++;
        if (state !== 3'd0 || instret !== exp_instret) begin
            n_bad++; $display("FAIL load_retire: got st=%0d ir=%h want st=0 ir=%h",
                              state, instret, exp_instret);
        end
    endtask

    task automatic test_store();
        logic [17:0] exp [4];
        instr = 32'h00112023;
        exp = '{f_rdy, dec, v(2,0,0,0,0,0,0,0,0,1,0,0), v(3,1,1,1,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            n_cmp++;
            if (outs() !== exp[i]) begin
                n_bad++; $display("FAIL store cyc%0d: got %b want %b", i, outs(), exp[i]);
            end
            @(posedge clk); #1;
        end
        exp_instret++;
        n_cmp++;
        if (state !== 3'd0 || instret !== exp_instret) begin
            n_bad++; $display("FAIL store_retire: got st=%0d ir=%h want st=0 ir=%h",
                              state, instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [5];
        logic        zr [5];
        logic        ls [5];
        int          tk [5];
        logic [17:0] exp [3];
        // BEQ z=1, BEQ z=0, BNE z=0, BLT lt=1, BGE lt=1
        ins = '{32'h00208063, 32'h00208063, 32'h00209063, 32'h0020C063, 32'h0020D063};
        zr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ls  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tk  = '{1, 0, 1, 1, 0};
        for (int c = 0; c < 5; c++) begin
            instr = ins[c];
            is_zero = zr[c];
            is_less = ls[c];
            exp = '{f_rdy, dec, v(2,0,0,0,0,tk[c],0,tk[c]*2,0,0,0,0)};
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1; #1;
                n_cmp++;
                if (outs() !== exp[i]) begin
                    n_bad++; $display("FAIL branch%0d cyc%0d: got %b want %b",
                                      c, i, outs(), exp[i]);
                end
                @(posedge clk); #1;
            end
            exp_instret++;
            n_cmp++;
            if (state !== 3'd0 || instret !== exp_instret) begin
                n_bad++; $display("FAIL branch%0d_retire: got st=%0d ir=%h want st=0 ir=%h",
                                  c, state, instret, exp_instret);
            end
        end
        is_zero = 1'b0;
        is_less = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [31:0] ins [4];
        int          a [4];
        int          pw [4];
        int          ps [4];
        int          wb [4];
        logic [17:0] exp [4];
        // ADDI, LUI, AUIPC, JAL
        ins = '{32'h00510093, 32'h123450B7, 32'h00001097, 32'h008000EF};
        a   = '{0, 2, 1, 1};
        pw  = '{0, 0, 0, 1};
        ps  = '{0, 0, 0, 1};
        wb  = '{0, 0, 0, 2};
        for (int c = 0; c < 4; c++) begin
            instr = ins[c];
            exp = '{f_rdy, dec, v(2,0,0,0,0,pw[c],0,ps[c],a[c],1,0,0),
                    v(4,0,0,0,0,0,1,0,0,0,wb[c],0)};
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1; #1;
                n_cmp++;
                if (outs() !== exp[i]) begin
                    n_bad++; $display("FAIL alu_op%0d cyc%0d: got %b want %b",
                                      c, i, outs(), exp[i]);
                end
                @(posedge clk); #1;
            end
            exp_instret++;
            n_cmp++;
            if (state !== 3'd0 || instret !== exp_instret) begin
                n_bad++; $display("FAIL alu_op%0d_retire: got st=%0d ir=%h want st=0 ir=%h",
                                  c, state, instret, exp_instret);
            end
        end
    endtask

    task automatic test_wrap();
        instr = 32'h003100B3;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        // Now in DECODE: preload the counter to its maximum.
        dut.instret_q = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (instret !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL wrap_preload: got %h want ffffffff", instret);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        exp_instret = 32'd0;
        n_cmp++;
        if (state !== 3'd0 || instret !== exp_instret) begin
            n_bad++; $display("FAIL wrap: got st=%0d ir=%h want st=0 ir=0", state, instret);
        end
    endtask

    task automatic test_trap_opcode();
        logic [17:0] trap;
        trap = v(5,0,0,0,0,0,0,0,0,0,0,1);
        instr = 32'h0000007F;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== dec) begin
            n_bad++; $display("FAIL trap_op_decode: got %b want %b", outs(), dec);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0]; #1;
            n_cmp++;
            if (outs() !== trap || instret !== exp_instret) begin
                n_bad++; $display("FAIL trap_op_hold cyc%0d: got %b ir=%h want %b ir=%h",
                                  i, outs(), instret, trap, exp_instret);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        exp_instret = 32'd0;
        n_cmp++;
        if (outs() !== f_wait || instret !== exp_instret) begin
            n_bad++; $display("FAIL trap_op_reset: got %b ir=%h want %b ir=0",
                              outs(), instret, f_wait);
        end
    endtask

    task automatic test_trap_branch();
        logic [17:0] exp [3];
        logic [17:0] trap;
        trap = v(5,0,0,0,0,0,0,0,0,0,0,1);
        instr = 32'h0020A063;
        is_zero = 1'b1;
        is_less = 1'b1;
        exp = '{f_rdy, dec, v(2,0,0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1; #1;
            n_cmp++;
            if (outs() !== exp[i]) begin
                n_bad++; $display("FAIL trap_br cyc%0d: got %b want %b", i, outs(), exp[i]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (outs() !== trap || instret !== exp_instret) begin
                n_bad++; $display("FAIL trap_br_hold cyc%0d: got %b ir=%h want %b ir=%h",
                                  i, outs(), instret, trap, exp_instret);
            end
            @(posedge clk); #1;
        end
        is_zero = 1'b0;
        is_less = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== f_wait) begin
            n_bad++; $display("FAIL trap_br_reset: got %b want %b", outs(), f_wait);
        end
    endtask

    task automatic test_reset_wait();
        instr = 32'h003100B3;
        mem_ready = 1'b0; #1;
        n_cmp++;
        if (outs() !== f_wait) begin
            n_bad++; $display("FAIL rst_wait_pre: got %b want %b", outs(), f_wait);
        end
        @(posedge clk); #1;
        // Memory answers in the same cycle reset arrives: must not load the IR.
        rst = 1'b1;
        mem_ready = 1'b1; #1;
        n_cmp++;
        if (outs() !== idle) begin
            n_bad++; $display("FAIL rst_wait_during: got %b want %b", outs(), idle);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0; #1;
        n_cmp++;
        if (outs() !== f_wait || instret !== 32'd0) begin
            n_bad++; $display("FAIL rst_wait_after: got %b ir=%h want %b ir=0",
                              outs(), instret, f_wait);
        end
        mem_ready = 1'b1; #1;
        n_cmp++;
        if (outs() !== f_rdy) begin
            n_bad++; $display("FAIL rst_wait_refetch: got %b want %b", outs(), f_rdy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        instr = 32'd0;
        mem_ready = 1'b0;
        is_zero = 1'b0;
        is_less = 1'b0;
        f_rdy  = v(0,1,0,0,1,1,0,0,0,0,0,0);
        f_wait = v(0,1,0,0,0,0,0,0,0,0,0,0);
        dec    = v(1,0,0,0,0,0,0,0,0,0,0,0);
        idle   = v(0,0,0,0,0,0,0,0,0,0,0,0);

        test_reset();
        test_add();
        test_fetch_wait();
        test_load();
        test_store();
        test_branch();
        test_alu_ops();
        test_wrap();
        test_trap_opcode();
        test_trap_branch();
        test_reset_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
